grey_code6_rx: RTL and testbench

Receive-side counterpart of the 6-bit Gray-code step counter. It samples a 6-bit Gray code driven from another clock domain or off-chip, synchronizes it, and decodes it to binary. Each legal single-step change becomes a one-cycle increment or decrement pulse; any illegal multi-step change is flagged and counted. It sits at the consumer end of a Gray-code link and restores the step events that the transmitting counter encoded.

---
 rtl/grey_pkg.sv | 22 ++
 rtl/grey_sync.sv | 24 ++
 rtl/grey_code6_rx.sv | 130 +++++++++++++
 tb/tb_grey_code6_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/grey_pkg.sv
// Shared widths, FSM encoding and Gray-to-binary decode for the Gray-code receiver.
package grey_pkg;

  localparam int unsigned GREY_W    = 6;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [0:0] {
    LOAD,
    TRACK
  } rx_state_e;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GREY_W-1:0] grey2bin(input logic [GREY_W-1:0] g);
    logic [GREY_W-1:0] b;
    b = g;
    for (int s = 1; s < int'(GREY_W); s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/grey_sync.sv
// Multi-flop bus synchronizer; only safe for buses that change one bit at a time.
module grey_sync #(
  parameter int unsigned Width  = 6,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Stages-1:0][Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], data_i};
    end
  end

  assign data_o = sync_q[Stages-1];

endmodule

// File: rtl/grey_code6_rx.sv
// Gray-code link receiver: synchronize, decode, and turn each code step into
// an incr/decr pulse, flagging and counting any multi-step jump.
module grey_code6_rx
  import grey_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GREY_W-1:0]    grey,
  input  logic                 err_clr,
  output logic [GREY_W-1:0]    bin,
  output logic                 incr,
  output logic                 decr,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked
);

  localparam int unsigned FillW = $clog2(SYNC_STAGES + 1);
  localparam logic [FillW-1:0] FillLast = FillW'(SYNC_STAGES);

  logic [GREY_W-1:0]    grey_sync_out;
  logic [GREY_W-1:0]    bin_d, bin_q;
  logic [GREY_W-1:0]    prev_d, prev_q;
  logic [GREY_W-1:0]    delta;
  logic [FillW-1:0]     fill_d, fill_q;
  rx_state_e            state_d, state_q;
  logic                 locked_d, locked_q;
  logic                 incr_d, incr_q;
  logic                 decr_d, decr_q;
  logic                 err_d, err_q;
  logic                 sticky_d, sticky_q;
  logic [ERR_CNT_W-1:0] cnt_d, cnt_q;

  grey_sync #(
    .Width  (GREY_W),
    .Stages (SYNC_STAGES)
  ) u_grey_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .data_i (grey),
    .data_o (grey_sync_out)
  );

  assign bin_d = grey2bin(grey_sync_out);
  assign delta = bin_q - prev_q;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    prev_d   = prev_q;
    locked_d = locked_q;
    incr_d   = 1'b0;
    decr_d   = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    // Clear first so a coincident error still counts as the first one.
    if (err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end

    unique case (state_q)
      LOAD: begin
        if (fill_q == FillLast) begin
          // Baseline is the value bin captures on this same edge.
          prev_d   = bin_d;
          locked_d = 1'b1;
          state_d  = TRACK;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      TRACK: begin
        prev_d = bin_q;
        if (delta == GREY_W'(1)) begin
          incr_d = 1'b1;
        end else if (delta == '1) begin
          decr_d = 1'b1;
        end else if (delta != '0) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          if (cnt_d != '1) begin
            cnt_d = cnt_d + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD;
      fill_q   <= '0;
      bin_q    <= '0;
      prev_q   <= '0;
      locked_q <= 1'b0;
      incr_q   <= 1'b0;
      decr_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      bin_q    <= bin_d;
      prev_q   <= prev_d;
      locked_q <= locked_d;
      incr_q   <= incr_d;
      decr_q   <= decr_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bin        = bin_q;
  assign incr       = incr_q;
  assign decr       = decr_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_grey_code6_rx.sv
// Bench for grey_code6_rx: directed scenarios plus random steps against an
// edge-indexed history model of the receiver.
module tb_grey_code6_rx;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] grey;
  logic       err_clr;
  logic [5:0] bin;
  logic       incr, decr, err, err_sticky, locked;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] dec_tbl [64];
  logic [5:0] hist [$];
  int         exp_cnt;
  bit         exp_sticky, exp_incr, exp_decr, exp_err;
  logic [5:0] rb;
  int         r;

  grey_code6_rx #(
    .SYNC_STAGES (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .grey       (grey),
    .err_clr    (err_clr),
    .bin        (bin),
    .incr       (incr),
    .decr       (decr),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Decoded value held on bin after edge c (edges counted from reset release).
  function automatic int bin_at(input int c);
    if (c <= S) return 0;
    return int'(dec_tbl[hist[c-S-1]]);
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_cnt    = 0;
    exp_sticky = 0;
    exp_incr   = 0;
    exp_decr   = 0;
    exp_err    = 0;
  endtask

  task automatic check_all(input string ph);
    int c;
    c = hist.size();
    check_eq({ph, ":bin"}, int'(bin), bin_at(c));
    check_eq({ph, ":locked"}, int'(locked), int'(c >= S + 1));
    check_eq({ph, ":incr"}, int'(incr), int'(exp_incr));
    check_eq({ph, ":decr"}, int'(decr), int'(exp_decr));
    check_eq({ph, ":err"}, int'(err), int'(exp_err));
    check_eq({ph, ":sticky"}, int'(err_sticky), int'(exp_sticky));
    check_eq({ph, ":cnt"}, int'(err_cnt), exp_cnt);
  endtask

  task automatic tick(input string ph);
    int c, d;
    @(posedge clk);
    hist.push_back(grey);
    c = hist.size();
    exp_incr = 0;
    exp_decr = 0;
    exp_err  = 0;
    if (c >= S + 3) begin
      d = (bin_at(c - 1) - bin_at(c - 2) + 64) % 64;
      if (d == 1) exp_incr = 1;
      else if (d == 63) exp_decr = 1;
      else if (d != 0) exp_err = 1;
    end
    if (err_clr) begin
      exp_cnt    = 0;
      exp_sticky = 0;
    end
    if (exp_err) begin
      exp_sticky = 1;
      if (exp_cnt < 255) exp_cnt++;
    end
    #1 check_all(ph);
  endtask

  task automatic hold(input logic [5:0] g, input int n, input string ph);
    grey = g;
    repeat (n) tick(ph);
  endtask

  initial begin
    for (int b = 0; b < 64; b++) dec_tbl[6'(b ^ (b >> 1))] = 6'(b);

    rst = 1'b0;
    grey = 6'b000111;
    err_clr = 1'b0;
    model_reset();
    #12 check_all("reset");
    @(negedge clk) rst = 1'b1;
    repeat (3) tick("lock");
    check_eq("lock_locked", int'(locked), 1);
    check_eq("lock_bin", int'(bin), 5);
    hold(6'b000111, 3, "lock_idle");

    hold(6'b000000, 6, "step0");
    hold(6'b000001, 4, "step1");
    hold(6'b000011, 4, "step2");
    check_eq("step_bin", int'(bin), 2);

    hold(6'b100000, 6, "wrap63");
    hold(6'b000000, 4, "wrap_up");
    hold(6'b100000, 4, "wrap_dn");
    hold(6'b000000, 4, "wrap_back");

    err_clr = 1'b1;
    tick("clr");
    err_clr = 1'b0;
    hold(6'b000011, 4, "jump");
    check_eq("jump_cnt", int'(err_cnt), 1);
    check_eq("jump_sticky", int'(err_sticky), 1);
    hold(6'b000010, 4, "jump_step");

    for (int i = 0; i < 300; i++) begin
      grey = (i % 2 == 0) ? 6'b000000 : 6'b000011;
      tick("sat");
    end
    hold(6'b000011, 3, "sat_flush");
    check_eq("sat_cnt", int'(err_cnt), 255);
    grey = 6'b000000;
    repeat (3) tick("clr_err");
    err_clr = 1'b1;
    tick("clr_err");
    err_clr = 1'b0;
    check_eq("clr_err_cnt", int'(err_cnt), 1);
    check_eq("clr_err_sticky", int'(err_sticky), 1);
    check_eq("clr_err_pulse", int'(err), 1);

    hold(6'b000111, 6, "pre_rst");
    rst = 1'b0;
    model_reset();
    #1 check_all("mid_rst");
    grey = 6'b001101;
    #20 check_all("mid_rst_hold");
    @(negedge clk) rst = 1'b1;
    repeat (3) tick("relock");
    check_eq("relock_bin", int'(bin), 9);
    check_eq("relock_locked", int'(locked), 1);
    hold(6'b001101, 4, "relock_idle");

    rb = 6'd9;
    repeat (400) begin
      r = int'($urandom_range(0, 15));
      if (r < 5) rb = rb + 6'd1;
      else if (r < 10) rb = rb - 6'd1;
      else if (r == 10) rb = 6'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      grey = rb ^ (rb >> 1);
      tick("rand");
    end
    err_clr = 1'b0;
    repeat (4) tick("rand_flush");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
